// File: rtl/pipe_hazard_pkg.sv
// Shared slot types, select encoding and parameter limits for the pipeline hazard unit.
// Register tags are stored zero-extended to TAG_W so the slot types stay fixed-width.
package pipe_hazard_pkg;

    localparam int TAG_W         = 8;
    localparam int RA_W_MAX      = TAG_W;
    localparam int FWD_DEPTH_MIN = 1;
    localparam int FWD_DEPTH_MAX = 4;
    localparam int MULTI_LAT_MIN = 2;
    localparam int MULTI_LAT_MAX = 16;

    localparam logic [2:0] FWD_RF = 3'd0;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t rs1;
        tag_t rs2;
        tag_t rd;
        logic regwrite;
        logic memread;
        logic multi;
    } ex_slot_t;

    typedef struct packed {
        logic valid;
        tag_t rd;
        logic regwrite;
        logic memread;
    } stage_slot_t;

    function automatic logic params_ok(int ra_w, int fwd_depth, int multi_lat);
        return (ra_w >= 1) && (ra_w <= RA_W_MAX) &&
               (fwd_depth >= FWD_DEPTH_MIN) && (fwd_depth <= FWD_DEPTH_MAX) &&
               (multi_lat >= MULTI_LAT_MIN) && (multi_lat <= MULTI_LAT_MAX);
    endfunction

    // A load sitting in stage 1 is never a forwarding source: the load-use stall keeps it from being needed.
    function automatic logic producer_hit(stage_slot_t s, logic is_slot1, tag_t rs);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == rs) && !(is_slot1 && s.memread);
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shadow shift register of destination tags for the producer stages after EX.
// slots[0] is stage 1 (EX/MEM); the oldest slot falls off the end.
module hazard_tag_pipe
    import pipe_hazard_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic                    bubble,
    input  stage_slot_t             head,
    output stage_slot_t [DEPTH-1:0] slots
);

    always_ff @(posedge clk) begin
        if (rst) begin
            slots <= '0;
        end else if (!hold) begin
            slots[0] <= bubble ? stage_slot_t'('0) : head;
            for (int k = 1; k < DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard unit for the in-order pipeline: forwarding selects, load-use and multi-cycle stalls,
// branch flush, and saturating stall/flush counters, all derived from a shadow tag pipeline.
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int RA_W      = 5,
    parameter int FWD_DEPTH = 2,
    parameter int MULTI_LAT = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [RA_W-1:0]  id_rs1_i,
    input  logic [RA_W-1:0]  id_rs2_i,
    input  logic [RA_W-1:0]  id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             id_multi_i,
    input  logic             br_taken_i,
    output logic             stall_o,
    output logic             ex_hold_o,
    output logic             flush_o,
    output logic [2:0]       fwd1_sel_o,
    output logic [2:0]       fwd2_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic PARAMS_OK = params_ok(RA_W, FWD_DEPTH, MULTI_LAT);
    localparam int   MCW       = $clog2(MULTI_LAT);

    ex_slot_t                    ex_q;
    ex_slot_t                    id_slot;
    stage_slot_t                 ex_tag;
    stage_slot_t [FWD_DEPTH-1:0] stage_q;
    logic [MCW-1:0]              multi_cnt_q;
    logic                        multi_busy;
    logic                        load_use;

    always_comb begin
        id_slot = '0;
        if (id_valid_i) begin
            id_slot.valid    = 1'b1;
            id_slot.rs1      = tag_t'(id_rs1_i);
            id_slot.rs2      = tag_t'(id_rs2_i);
            id_slot.rd       = tag_t'(id_rd_i);
            id_slot.regwrite = id_regwrite_i;
            id_slot.memread  = id_memread_i;
            id_slot.multi    = id_multi_i;
        end
    end

    assign ex_tag = '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite, memread: ex_q.memread};

    assign multi_busy = ex_q.multi && (multi_cnt_q != '0);
    assign load_use   = id_valid_i && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                        ((ex_q.rd == id_slot.rs1) || (ex_q.rd == id_slot.rs2));

    // Flush outranks the multi-cycle hold, which outranks the load-use stall.
    assign flush_o   = br_taken_i && !rst_i;
    assign ex_hold_o = multi_busy && !br_taken_i && !rst_i;
    assign stall_o   = (multi_busy || load_use) && !br_taken_i && !rst_i;

    always_comb begin
        fwd1_sel_o = FWD_RF;
        fwd2_sel_o = FWD_RF;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (producer_hit(stage_q[k-1], k == 1, ex_q.rs1)) fwd1_sel_o = 3'(k);
            if (producer_hit(stage_q[k-1], k == 1, ex_q.rs2)) fwd2_sel_o = 3'(k);
        end
        if (rst_i) begin
            fwd1_sel_o = FWD_RF;
            fwd2_sel_o = FWD_RF;
        end
    end

    // Downstream stages never stall, so the tag pipe always advances.
    hazard_tag_pipe #(
        .DEPTH (FWD_DEPTH)
    ) u_tag_pipe (
        .clk    (clk_i),
        .rst    (rst_i),
        .hold   (1'b0),
        .bubble (br_taken_i || multi_busy),
        .head   (ex_tag),
        .slots  (stage_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            multi_cnt_q <= '0;
        end else if (br_taken_i) begin
            ex_q        <= '0;
            multi_cnt_q <= '0;
        end else if (multi_busy) begin
            multi_cnt_q <= multi_cnt_q - 1'b1;
        end else if (load_use) begin
            ex_q <= '0;
        end else begin
            ex_q        <= id_slot;
            multi_cnt_q <= id_slot.multi ? MCW'(MULTI_LAT - 1) : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_o && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) assert (PARAMS_OK);
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed hazard scenarios plus randomized traffic, every cycle
// checked against an instruction-level model of the pipeline.
module tb_pipe_hazard_unit;

    localparam int RA_W  = 5;
    localparam int D     = 3;
    localparam int ML    = 3;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic [RA_W-1:0]  id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_multi;
    logic             br_taken;
    logic             stall;
    logic             ex_hold;
    logic             flush;
    logic [2:0]       fwd1_sel;
    logic [2:0]       fwd2_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_hazard_unit #(
        .RA_W      (RA_W),
        .FWD_DEPTH (D),
        .MULTI_LAT (ML),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .id_multi_i    (id_multi),
        .br_taken_i    (br_taken),
        .stall_o       (stall),
        .ex_hold_o     (ex_hold),
        .flush_o       (flush),
        .fwd1_sel_o    (fwd1_sel),
        .fwd2_sel_o    (fwd2_sel),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-level model: one record in EX plus a queue of producers (index 0 = stage 1).
    typedef struct {
        bit v;
        int rs1;
        int rs2;
        int rd;
        bit rw;
        bit mr;
        bit mul;
    } instr_t;

    instr_t m_ex;
    int     m_age;
    instr_t m_prod[$];
    int     m_stall_cnt;
    int     m_flush_cnt;

    function automatic instr_t no_instr();
        instr_t t;
        t = '{v: 0, rs1: 0, rs2: 0, rd: 0, rw: 0, mr: 0, mul: 0};
        return t;
    endfunction

    function automatic instr_t cur_id();
        instr_t t;
        t = '{v: 1, rs1: int'(id_rs1), rs2: int'(id_rs2), rd: int'(id_rd),
              rw: id_regwrite, mr: id_memread, mul: id_multi};
        return t;
    endfunction

    function automatic int exp_sel(int rs);
        for (int k = 1; k <= D; k++) begin
            if (m_prod[k-1].v && m_prod[k-1].rw && m_prod[k-1].rd != 0 &&
                m_prod[k-1].rd == rs && !(k == 1 && m_prod[k-1].mr)) return k;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_ex  = no_instr();
        m_age = 0;
        m_prod.delete();
        for (int k = 0; k < D; k++) m_prod.push_back(no_instr());
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic check(string tag, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already applied: compare, advance the model, move to next negedge.
    task automatic tick();
        bit fl, busy, lu;
        bit e_stall, e_hold;
        #1;
        fl      = br_taken && !rst;
        busy    = m_ex.v && m_ex.mul && (m_age < ML);
        lu      = id_valid && m_ex.v && m_ex.mr && m_ex.rd != 0 &&
                  (m_ex.rd == int'(id_rs1) || m_ex.rd == int'(id_rs2));
        e_hold  = busy && !fl && !rst;
        e_stall = (busy || lu) && !fl && !rst;
        check("flush", int'(flush), int'(fl));
        check("ex_hold", int'(ex_hold), int'(e_hold));
        check("stall", int'(stall), int'(e_stall));
        check("fwd1_sel", int'(fwd1_sel), rst ? 0 : exp_sel(m_ex.rs1));
        check("fwd2_sel", int'(fwd2_sel), rst ? 0 : exp_sel(m_ex.rs2));
        check("stall_cnt", int'(stall_cnt), m_stall_cnt);
        check("flush_cnt", int'(flush_cnt), m_flush_cnt);
        if (rst) begin
            model_reset();
        end else begin
            if (e_stall && m_stall_cnt < CMAX) m_stall_cnt++;
            if (fl && m_flush_cnt < CMAX) m_flush_cnt++;
            m_prod.push_front((fl || busy) ? no_instr() : m_ex);
            void'(m_prod.pop_back());
            if (fl) begin
                m_ex  = no_instr();
                m_age = 0;
            end else if (busy) begin
                m_age++;
            end else if (lu) begin
                m_ex  = no_instr();
                m_age = 0;
            end else begin
                m_ex  = id_valid ? cur_id() : no_instr();
                m_age = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_id(bit v, int r1, int r2, int rd, bit rw, bit mr, bit mul);
        rst         = 1'b0;
        br_taken    = 1'b0;
        id_valid    = v;
        id_rs1      = RA_W'(r1);
        id_rs2      = RA_W'(r2);
        id_rd       = RA_W'(rd);
        id_regwrite = rw;
        id_memread  = mr;
        id_multi    = mul;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        nop();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        nop();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Producer in stage 1, 2 and 3.
        set_id(1, 1, 2, 5, 1, 0, 0); tick();
        set_id(1, 5, 5, 6, 1, 0, 0); tick();
        check("dep_sel1_rs1", int'(fwd1_sel), 1);
        check("dep_sel1_rs2", int'(fwd2_sel), 1);
        set_id(1, 1, 2, 5, 1, 0, 0); tick();
        set_id(1, 3, 4, 9, 1, 0, 0); tick();
        set_id(1, 5, 5, 6, 1, 0, 0); tick();
        check("dep_sel2", int'(fwd1_sel), 2);
        set_id(1, 1, 2, 5, 1, 0, 0); tick();
        nop(); tick();
        nop(); tick();
        set_id(1, 5, 3, 6, 1, 0, 0); tick();
        check("dep_sel3", int'(fwd1_sel), 3);

        // Youngest of two producers wins; x0 never forwards.
        set_id(1, 1, 2, 5, 1, 0, 0); tick();
        set_id(1, 1, 2, 5, 1, 0, 0); tick();
        set_id(1, 5, 5, 6, 1, 0, 0); tick();
        check("double_prod", int'(fwd2_sel), 1);
        set_id(1, 1, 2, 0, 1, 0, 0); tick();
        set_id(1, 0, 0, 7, 1, 0, 0); tick();
        check("x0_rs1", int'(fwd1_sel), 0);
        check("x0_rs2", int'(fwd2_sel), 0);

        // Load-use: one stall cycle, then forward from stage 2.
        do_reset();
        set_id(1, 1, 0, 7, 1, 1, 0); tick();
        set_id(1, 7, 1, 8, 1, 0, 0);
        #1 check("lu_stall", int'(stall), 1);
        tick();
        #1 check("lu_one_cycle", int'(stall), 0);
        tick();
        check("lu_fwd", int'(fwd1_sel), 2);
        check("lu_cnt", int'(stall_cnt), 1);

        // Multi-cycle op held for ML-1 cycles, dependent op forwards from stage 1.
        do_reset();
        set_id(1, 1, 2, 9, 1, 0, 1); tick();
        set_id(1, 9, 3, 10, 1, 0, 0);
        #1 check("mul_hold_a", int'(ex_hold), 1);
        check("mul_stall_a", int'(stall), 1);
        tick();
        check("mul_hold_b", int'(ex_hold), 1);
        tick();
        check("mul_release", int'(ex_hold), 0);
        tick();
        check("mul_fwd", int'(fwd1_sel), 1);
        tick();

        // Branch flush while a multi op is held.
        do_reset();
        set_id(1, 1, 2, 9, 1, 0, 1); tick();
        nop();
        br_taken = 1'b1;
        #1 check("flush_out", int'(flush), 1);
        check("flush_no_stall", int'(stall), 0);
        tick();
        nop();
        #1 check("flush_abort", int'(ex_hold), 0);
        check("flush_cnt", int'(flush_cnt), 1);
        tick();

        // Reset in the middle of a multi op.
        set_id(1, 1, 2, 9, 1, 0, 1); tick();
        nop();
        rst = 1'b1;
        tick();
        check("rst_hold", int'(ex_hold), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_fwd", int'(fwd1_sel), 0);
        rst = 1'b0;
        tick();
        check("rst_after", int'(ex_hold), 0);

        // Stall counter saturation.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_id(1, 1, 0, 7, 1, 1, 0); tick();
            set_id(1, 2, 7, 8, 1, 0, 0); tick();
            tick();
        end
        check("stall_sat", int'(stall_cnt), 15);

        // Randomized traffic on a small register set to provoke hazards.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            br_taken    = ($urandom_range(0, 9) == 0);
            id_valid    = ($urandom_range(0, 7) != 0);
            id_rs1      = RA_W'($urandom_range(0, 3));
            id_rs2      = RA_W'($urandom_range(0, 3));
            id_rd       = RA_W'($urandom_range(0, 3));
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_memread  = ($urandom_range(0, 3) == 0);
            id_multi    = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised successor to the fixed two-source forwarding logic of the 5-stage RISC-V pipeline.
- Keeps its own shadow pipeline of in-flight destination tags, one slot per stage from EX to the last forwarding stage.
- From these tags it generates forwarding selects for FWD_DEPTH producer stages, load-use stalls, multi-cycle EX-op stalls and branch flushes.
- Sits beside the pipeline registers and drives PC/IF_ID hold, ID_EX bubble and the EX operand MUXes.

Parameters:
- RA_W, 5, register address width; register 0 never forwards.
- FWD_DEPTH, 2, number of producer stages after EX (1=EX/MEM, 2=MEM/WB, 3=extra WB buffer ...); range 1-4.
- MULTI_LAT, 3, total EX cycles of a multi-cycle op (MUL/DIV); range 2-16.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs1_i  in  RA_W  ID source 1
- id_rs2_i  in  RA_W  ID source 2
- id_rd_i  in  RA_W  ID destination
- id_regwrite_i  in  1  ID instruction writes rd
- id_memread_i  in  1  ID instruction is a load
- id_multi_i  in  1  ID instruction is a multi-cycle EX op
- br_taken_i  in  1  branch resolved taken in EX/MEM this cycle
- stall_o  out  1  hold PC and IF_ID; insert bubble into ID_EX
- ex_hold_o  out  1  hold ID_EX and EX operands; bubble into EX_MEM
- flush_o  out  1  kill IF_ID and ID_EX contents
- fwd1_sel_o  out  3  EX operand 1 source: 0=register file, k=stage k
- fwd2_sel_o  out  3  EX operand 2 source, same encoding
- stall_cnt_o  out  CNT_W  cycles with stall_o=1, saturating
- flush_cnt_o  out  CNT_W  cycles with flush_o=1, saturating

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous and active-high on rst_i.
- Reset state: all slots invalid, multi counter 0, perf counters 0.
- Outputs while rst_i=1: stall_o, ex_hold_o, flush_o forced 0; fwd selects 0.
- Slots:
  - EX slot holds {valid, rs1, rs2, rd, regwrite, memread, multi}.
  - Stage slots 1..FWD_DEPTH hold {valid, rd, regwrite, memread}.
- Outputs are combinational from registered state plus current inputs; all state updates on the rising clk_i edge.
- Forwarding:
  - fwdN_sel = smallest k for which slot k is valid, regwrite, rd!=0 and rd==EX.rsN; else 0.
  - Youngest producer wins.
  - A load in slot 1 never matches: the load-use stall guarantees it cannot be needed there.
- Load-use:
  - Condition: EX slot valid and memread, rd!=0, and (rd==id_rs1_i or rd==id_rs2_i), with id_valid_i=1.
  - Response: stall_o=1 for exactly 1 cycle; a bubble enters the EX slot.
- Multi-cycle op:
  - Loading a multi op into the EX slot sets cnt=MULTI_LAT-1.
  - While cnt!=0: ex_hold_o=1 and stall_o=1; EX slot unchanged; bubble into slot 1; cnt decrements.
  - The op advances on the cycle after cnt reaches 0.
  - Back-to-back multi ops each take MULTI_LAT cycles.
- Flush: flush_o = br_taken_i. Next edge:
  - EX slot invalidated; ID input ignored.
  - cnt cleared, aborting any multi op in EX.
  - Slot 1 receives a bubble.
- Priority: flush > multi hold > load-use. stall_o and ex_hold_o are 0 in any cycle with flush_o=1.
- Shift: when not held, slot k+1 <= slot k and slot 1 <= EX slot. The oldest slot is dropped.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Package pipe_hazard_pkg:
  - ex_slot_t and stage_slot_t structs.
  - FWD_RF=0 select constant.
  - Range-check localparams.
- One sub-module, hazard_tag_pipe: parametrised FWD_DEPTH shift register of stage_slot_t with hold and bubble-insert inputs.
- Top module contains the compare/priority logic, multi counter and perf counters.

Test Plan:
- Dependencies: add x5 then add x6,x5,x5 next cycle -> fwd1_sel=fwd2_sel=1. Same with one independent instruction between -> sel=2. With FWD_DEPTH=3 and two between -> sel=3.
- Double producer: x5 written by both slot 1 and slot 2 -> sel=1. rd=x0 producer -> sel=0.
- Load-use: lw x7 in EX, ID add x8,x7,x1 -> stall_o=1 for one cycle. Next cycle fwd1_sel=2, stall_cnt_o=1.
- Multi op: mul in EX with MULTI_LAT=3 -> ex_hold_o=stall_o=1 for 2 cycles, slot 1 bubbles. A dependent add after it gets fwd sel=1.
- Flush: br_taken_i=1 while a mul is held -> flush_o=1, stall_o=0. EX slot invalid next cycle, cnt=0, flush_cnt_o=1.
- Reset and saturation: rst_i asserted mid multi-op -> next cycle all outputs 0, slots invalid. With CNT_W=4, 20 load-use stalls -> stall_cnt_o=15.
